// File: rtl/link_pkg.sv
// Shared types and constants for the Game Boy link-port peer.
package link_pkg;

  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  DEFAULT_FILL = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StGap
  } state_t;

endpackage

// File: rtl/link_fifo.sv
// Synchronous 8-bit TX FIFO; push while full and pop while empty are ignored.
module link_fifo
  import link_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic [CNT_W-1:0] count
);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push && (count != CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/link_peer.sv
// Game Boy serial link peer: drives the link clock (master) or follows it (slave),
// exchanging one MSB-first byte per transfer with a 4-deep TX FIFO.
module link_peer
  import link_pkg::*;
#(
  parameter int unsigned HALF_DIV = 256,
  parameter int unsigned GAP      = 64,
  parameter int unsigned TIMEOUT  = 4096,
  parameter logic [7:0]  FILL     = DEFAULT_FILL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy,
  input  logic       serial_clk_in,
  input  logic       serial_data_in,
  output logic       serial_clk_out,
  output logic       serial_data_out
);

  localparam int unsigned MAX_HG  = (HALF_DIV > GAP) ? HALF_DIV : GAP;
  localparam int unsigned MAX_CNT = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
  localparam int unsigned DIV_W   = $clog2(MAX_CNT + 1);
  localparam logic [DIV_W-1:0] HALF_END    = DIV_W'(HALF_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_END     = DIV_W'(GAP - 1);
  localparam logic [DIV_W-1:0] TIMEOUT_END = DIV_W'(TIMEOUT - 1);

  logic [2:0]       sc_sync_q;  // [0]=stage 1, [1]=stage 2, [2]=edge-detect stage
  logic [1:0]       sd_sync_q;
  state_t           state_q;
  logic             master_q;
  logic [3:0]       bit_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       shift_q;

  logic [CNT_W-1:0] fifo_count;
  logic [7:0]       fifo_rdata, load_byte;
  logic             fifo_empty, fifo_pop, sd_in;
  logic             sc_fall, sc_rise, mode_chg, start_slave, start_master;

  link_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .pop   (fifo_pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign tx_ready     = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_count == '0);
  assign sd_in        = sd_sync_q[1];
  assign sc_fall      = sc_sync_q[2] & ~sc_sync_q[1];
  assign sc_rise      = ~sc_sync_q[2] & sc_sync_q[1];
  assign mode_chg     = (master != master_q);
  assign start_slave  = !master && !mode_chg && !busy && sc_fall && (bit_cnt_q == '0);
  assign start_master = master && !mode_chg && (state_q == StIdle) && !fifo_empty;
  assign fifo_pop     = (start_slave || start_master) && !fifo_empty;
  assign load_byte    = fifo_empty ? FILL : fifo_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_sync_q <= 3'b111;
      sd_sync_q <= 2'b11;
    end else begin
      sc_sync_q <= {sc_sync_q[1:0], serial_clk_in};
      sd_sync_q <= {sd_sync_q[0], serial_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      master_q        <= master;
      bit_cnt_q       <= '0;
      div_q           <= '0;
      shift_q         <= '0;
      rx_data         <= 8'h00;
      rx_valid        <= 1'b0;
      tx_underrun     <= 1'b0;
      busy            <= 1'b0;
      serial_clk_out  <= 1'b1;
      serial_data_out <= 1'b1;
    end else begin
      master_q    <= master;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (mode_chg) begin
        // Switching roles drops any byte in flight; its popped data is lost.
        state_q         <= StIdle;
        bit_cnt_q       <= '0;
        div_q           <= '0;
        busy            <= 1'b0;
        serial_clk_out  <= 1'b1;
        serial_data_out <= 1'b1;
      end else if (!master) begin
        if (start_slave) begin
          shift_q         <= load_byte;
          serial_data_out <= load_byte[7];
          tx_underrun     <= fifo_empty;
          busy            <= 1'b1;
          div_q           <= '0;
        end else if (busy) begin
          if (sc_rise) begin
            shift_q <= {shift_q[6:0], sd_in};
            div_q   <= '0;
            if (bit_cnt_q == 4'd7) begin
              rx_data         <= {shift_q[6:0], sd_in};
              rx_valid        <= 1'b1;
              busy            <= 1'b0;
              bit_cnt_q       <= '0;
              serial_data_out <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sc_fall) begin
            serial_data_out <= shift_q[7];
            div_q           <= '0;
          end else if (div_q == TIMEOUT_END) begin
            busy            <= 1'b0;
            bit_cnt_q       <= '0;
            div_q           <= '0;
            serial_data_out <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_master) begin
              shift_q         <= load_byte;
              serial_data_out <= load_byte[7];
              serial_clk_out  <= 1'b0;
              busy            <= 1'b1;
              bit_cnt_q       <= '0;
              div_q           <= '0;
              state_q         <= StLow;
            end
          end
          StLow: begin
            if (div_q == HALF_END) begin
              div_q          <= '0;
              serial_clk_out <= 1'b1;
              shift_q        <= {shift_q[6:0], sd_in};
              bit_cnt_q      <= bit_cnt_q + 1'b1;
              state_q        <= StHigh;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          StHigh: begin
            if (div_q == HALF_END) begin
              div_q <= '0;
              if (bit_cnt_q == 4'd8) begin
                rx_data         <= shift_q;
                rx_valid        <= 1'b1;
                busy            <= 1'b0;
                bit_cnt_q       <= '0;
                serial_data_out <= 1'b1;
                state_q         <= StGap;
              end else begin
                serial_clk_out  <= 1'b0;
                serial_data_out <= shift_q[7];
                state_q         <= StLow;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          StGap: begin
            if (div_q == GAP_END) begin
              div_q   <= '0;
              state_q <= StIdle;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/link_peer.md
LINK_PEER -- requirements
Module: link_peer

Interface
REQ-001 Parameter: HALF_DIV, default 256, serial clock half-period in clk cycles (8192 Hz bit rate at 4.19 MHz clk).
REQ-002 Parameter: GAP, default 64, idle clk cycles between consecutive master-mode bytes.
REQ-003 Parameter: TIMEOUT, default 4096, slave-mode partial-byte abort limit in clk cycles.
REQ-004 Parameter: FILL, default 8'hFF, byte shifted out when TX FIFO is empty.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 master  in  1  1 = peer drives serial clock; 0 = peer follows the Game Boy clock.
REQ-008 tx_data  in  8  host byte to send.
REQ-009 tx_valid  in  1  host push request.
REQ-010 tx_ready  out  1  TX FIFO not full.
REQ-011 rx_data  out  8  last byte received from the Game Boy.
REQ-012 rx_valid  out  1  one-cycle strobe; rx_data is valid.
REQ-013 tx_underrun  out  1  one-cycle strobe; FILL was loaded because FIFO was empty.
REQ-014 busy  out  1  byte transfer in progress.
REQ-015 serial_clk_in  in  1  Game Boy SC line, asynchronous.
REQ-016 serial_data_in  in  1  Game Boy SO line, asynchronous.
REQ-017 serial_clk_out  out  1  clock driven toward the Game Boy, idle high.
REQ-018 serial_data_out  out  1  data toward the Game Boy SI line, idle high.

Function
REQ-019 The block SHALL transfer MSB first; output bits change on serial clock falling edges, and input bits are sampled on rising edges.
REQ-020 serial_clk_in and serial_data_in SHALL be synchronised through two flip-flops; edge detection SHALL compare stage 2 with stage 3, giving 3-cycle edge latency.
REQ-021 TX buffering SHALL use a 4-entry FIFO; push occurs when tx_valid && tx_ready; simultaneous push and pop SHALL both take effect when not full; push while full SHALL be ignored.
REQ-022 At byte start, shift SHALL load the FIFO head (pop) or, if empty, FILL with a tx_underrun pulse.
REQ-023 Slave mode: the first falling edge with bit count 0 SHALL start a byte (REQ-022), set busy, and drive serial_data_out = byte[7] in the same cycle the edge is detected.
REQ-024 Slave mode: subsequent falling edges SHALL drive the next shift bit; each rising edge SHALL shift serial_data_in into the LSB and increment the bit count.
REQ-025 On the 8th rising edge, rx_data SHALL be updated and rx_valid pulsed in the next cycle; busy SHALL clear and the bit count SHALL return to 0.
REQ-026 Slave mode: if busy and no edge occurs for TIMEOUT cycles, the byte SHALL be aborted: bit count 0, busy 0, no rx_valid, and the popped byte SHALL be lost.
REQ-027 Master FSM states: IDLE, LOW, HIGH, GAP.
REQ-028 IDLE -> LOW when the FIFO is non-empty: load per REQ-022, drive serial_clk_out low and serial_data_out = bit 7, and set busy.
REQ-029 LOW -> HIGH after HALF_DIV cycles: drive serial_clk_out high and sample synchronised serial_data_in.
REQ-030 HIGH -> LOW after HALF_DIV cycles while bits remain, driving the next bit.
REQ-031 After the 8th HIGH phase the FSM SHALL enter GAP and pulse rx_valid; GAP -> IDLE after GAP cycles.
REQ-032 Master mode SHALL never start a byte on an empty FIFO; tx_underrun is therefore a slave-only event.
REQ-033 In master mode, serial_clk_in SHALL be ignored.
REQ-034 A change of master mid-byte SHALL abort the byte as in REQ-026, force serial_clk_out high, and return the FSM to IDLE.
REQ-035 Bit counter SHALL be 4 bits, and the divider SHALL be wide enough for max(HALF_DIV, GAP, TIMEOUT).

Reset
REQ-036 On rst, the block SHALL: empty the FIFO, set tx_ready=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, busy=0, serial_clk_out=1, serial_data_out=1, FSM=IDLE, bit count 0.
REQ-037 On rst, all synchroniser stages SHALL be set to 1.
REQ-038 rst mid-byte SHALL discard the byte without an rx_valid strobe.

Structure
REQ-039 Package link_pkg SHALL hold the FSM state enum, FIFO_DEPTH=4 and the default FILL.
REQ-040 The FIFO SHALL be a sub-module, link_fifo (synchronous, 8-bit wide, depth FIFO_DEPTH, count output).

Verification
REQ-041 Slave, push 8'hA5, Game Boy model clocks 8'h3C at 8192 Hz -> model receives A5, rx_data=3C with one rx_valid pulse.
REQ-042 Slave, empty FIFO, 1 byte clocked -> model receives FF, tx_underrun pulses once.
REQ-043 Master, push 8'h12, 8'h34 -> 16 clock pulses of 2*HALF_DIV period, GAP idle cycles between bytes, model receives 12 then 34.
REQ-044 Push 5 bytes back-to-back -> tx_ready low after 4, 5th push ignored.
REQ-045 Slave, 3 bits then silence for TIMEOUT+1 cycles -> busy=0, no rx_valid, next full byte received correctly.
REQ-046 Master mid-byte deassert, or rst mid-byte -> serial_clk_out=1 within 1 cycle, no rx_valid.
